// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence detector: latches a pattern/length/overlap/frame
// configuration, then counts pattern matches over exactly one frame of input bits.
module seq_det_ctrl #(
  parameter int MAXLEN = 8,
  parameter int CNTW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [4:0]        cfg_len,
  input  logic              cfg_overlap,
  input  logic [15:0]       cfg_frame,
  input  logic              start,
  input  logic              abort,
  input  logic              i_valid,
  input  logic              i,
  output logic              q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNTW-1:0]   match_cnt
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [MAXLEN-1:0] pat_reg, pat_next;
  logic [4:0]        len_reg, len_next;
  logic              ovl_reg, ovl_next;
  logic [15:0]       frame_reg, frame_next;
  logic [MAXLEN-1:0] hist_reg, hist_next;
  logic [4:0]        fill_reg, fill_next;
  logic [15:0]       rem_reg, rem_next;
  logic              q_reg, q_next;
  logic              err_reg, err_next;
  logic [CNTW-1:0]   cnt_reg, cnt_next;

  logic [MAXLEN-1:0] len_mask;
  logic [MAXLEN-1:0] hist_shift;
  logic [4:0]        fill_inc;
  logic              hit;
  logic              cfg_ok;

  // Only the low len bits of history take part in the comparison.
  genvar gi;
  generate
    for (gi = 0; gi < MAXLEN; gi++) begin : g_mask
      assign len_mask[gi] = (5'(gi) < len_reg);
    end
  endgenerate

  assign hist_shift = {hist_reg[MAXLEN-2:0], i};
  assign fill_inc   = (fill_reg == 5'(MAXLEN)) ? fill_reg : fill_reg + 5'd1;
  assign hit        = (fill_inc >= len_reg) &&
                      (((hist_shift ^ pat_reg) & len_mask) == '0);
  assign cfg_ok     = (cfg_len != 5'd0) && (cfg_len <= 5'(MAXLEN)) &&
                      (cfg_frame != 16'd0);

  always_comb begin
    state_next = state_reg;
    pat_next   = pat_reg;
    len_next   = len_reg;
    ovl_next   = ovl_reg;
    frame_next = frame_reg;
    hist_next  = hist_reg;
    fill_next  = fill_reg;
    rem_next   = rem_reg;
    cnt_next   = cnt_reg;
    q_next     = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_ok) begin
            pat_next   = cfg_pattern;
            len_next   = cfg_len;
            ovl_next   = cfg_overlap;
            frame_next = cfg_frame;
            state_next = ARMED;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ARMED: begin
        if (abort) begin
          state_next = IDLE;
        end else if (start) begin
          state_next = RUN;
          cnt_next   = '0;
          hist_next  = '0;
          fill_next  = '0;
          rem_next   = frame_reg;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (i_valid) begin
          hist_next = hist_shift;
          rem_next  = rem_reg - 16'd1;
          // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
          fill_next = (hit && !ovl_reg) ? 5'd0 : fill_inc;
          if (hit) begin
            q_next = 1'b1;
            if (!(&cnt_reg)) cnt_next = cnt_reg + CNTW'(1);
          end
          if (rem_reg == 16'd1) state_next = DONE;
        end
      end
      DONE: begin
        state_next = abort ? IDLE : ARMED;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pat_reg   <= '0;
      len_reg   <= '0;
      ovl_reg   <= 1'b0;
      frame_reg <= '0;
      hist_reg  <= '0;
      fill_reg  <= '0;
      rem_reg   <= '0;
      cnt_reg   <= '0;
      q_reg     <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pat_reg   <= pat_next;
      len_reg   <= len_next;
      ovl_reg   <= ovl_next;
      frame_reg <= frame_next;
      hist_reg  <= hist_next;
      fill_reg  <= fill_next;
      rem_reg   <= rem_next;
      cnt_reg   <= cnt_next;
      q_reg     <= q_next;
      err_reg   <= err_next;
    end
  end

  assign cfg_ready = (state_reg == IDLE);
  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign q         = q_reg;
  assign err       = err_reg;
  assign match_cnt = cnt_reg;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl; a second CNTW=2 instance shares the inputs
// so counter saturation can be observed alongside the default-width counter.
module tb_seq_det_ctrl;
  logic        clk = 1'b0;
  logic        rst, cfg_valid, cfg_overlap, start, abort, i_valid, i;
  logic [7:0]  cfg_pattern;
  logic [4:0]  cfg_len;
  logic [15:0] cfg_frame;
  logic        cfg_ready, q, busy, done, err;
  logic [7:0]  match_cnt;
  logic        s_cfg_ready, s_q, s_busy, s_done, s_err;
  logic [1:0]  s_match_cnt;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_det_ctrl #(.MAXLEN(8), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_frame(cfg_frame), .start(start), .abort(abort), .i_valid(i_valid),
    .i(i), .q(q), .busy(busy), .done(done), .err(err), .match_cnt(match_cnt));

  seq_det_ctrl #(.MAXLEN(8), .CNTW(2)) dut_sat (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(s_cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_frame(cfg_frame), .start(start), .abort(abort), .i_valid(i_valid),
    .i(i), .q(s_q), .busy(s_busy), .done(s_done), .err(s_err), .match_cnt(s_match_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [7:0] p, input logic [4:0] l,
                           input logic o, input logic [15:0] f);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_frame = f;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic go_idle();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic feed(input logic b);
    i_valid = 1'b1; i = b;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready got=%0b want=1", cfg_ready); end
    total++; if ({q, busy, done, err} !== 4'b0000) begin bad++; $display("FAIL reset_outs got=%b want=0000", {q, busy, done, err}); end
    total++; if (match_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", match_cnt); end
    $display("test_reset complete");
  endtask

  task automatic test_overlap();
    logic [4:0] stream;
    logic [4:0] qv;
    stream = 5'b10101; qv = '0;
    configure(8'b101, 5'd3, 1'b1, 16'd5);
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL ovl_cfg_ready got=%0b want=0", cfg_ready); end
    do_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ovl_busy got=%0b want=1", busy); end
    for (int k = 4; k >= 0; k--) begin
      total++; if (done !== 1'b0) begin bad++; $display("FAIL ovl_early_done bit=%0d got=%0b want=0", 4 - k, done); end
      feed(stream[k]);
      qv = {qv[3:0], q};
    end
    total++; if (qv !== 5'b00101) begin bad++; $display("FAIL ovl_q got=%b want=00101", qv); end
    total++; if (match_cnt !== 8'd2) begin bad++; $display("FAIL ovl_cnt got=%0d want=2", match_cnt); end
    total++; if ({done, busy} !== 2'b10) begin bad++; $display("FAIL ovl_done got=%b want=10", {done, busy}); end
    tick();
    total++; if ({done, busy, cfg_ready} !== 3'b000) begin bad++; $display("FAIL ovl_armed got=%b want=000", {done, busy, cfg_ready}); end
    go_idle();
    $display("test_overlap q=%b cnt=%0d", qv, match_cnt);
  endtask

  task automatic test_nonoverlap();
    logic [5:0] stream;
    logic [5:0] qv;
    stream = 6'b010101; qv = '0;
    configure(8'b101, 5'd3, 1'b0, 16'd5);
    do_start();
    for (int k = 4; k >= 0; k--) begin feed(stream[k]); qv = {qv[4:0], q}; end
    total++; if (qv[4:0] !== 5'b00100) begin bad++; $display("FAIL novl_q got=%b want=00100", qv[4:0]); end
    total++; if (match_cnt !== 8'd1) begin bad++; $display("FAIL novl_cnt got=%0d want=1", match_cnt); end
    tick();
    // Same configuration reused; count must clear on start.
    stream = 6'b010110; qv = '0;
    do_start();
    total++; if (match_cnt !== 8'd0) begin bad++; $display("FAIL novl_clear got=%0d want=0", match_cnt); end
    for (int k = 4; k >= 0; k--) begin feed(stream[k]); qv = {qv[4:0], q}; end
    total++; if (match_cnt !== 8'd1 || done !== 1'b1) begin bad++; $display("FAIL novl_rerun got cnt=%0d done=%0b want cnt=1 done=1", match_cnt, done); end
    tick();
    go_idle();
    stream = 6'b101101; qv = '0;
    configure(8'b101, 5'd3, 1'b0, 16'd6);
    do_start();
    for (int k = 5; k >= 0; k--) begin feed(stream[k]); qv = {qv[4:0], q}; end
    total++; if (qv !== 6'b001001) begin bad++; $display("FAIL novl6_q got=%b want=001001", qv); end
    total++; if (match_cnt !== 8'd2) begin bad++; $display("FAIL novl6_cnt got=%0d want=2", match_cnt); end
    tick();
    go_idle();
    $display("test_nonoverlap cnt=%0d", match_cnt);
  endtask

  task automatic test_illegal();
    logic [4:0]  lens [3];
    logic [15:0] frames [3];
    lens = '{5'd0, 5'd9, 5'd3};
    frames = '{16'd5, 16'd5, 16'd0};
    for (int k = 0; k < 3; k++) begin
      configure(8'b101, lens[k], 1'b1, frames[k]);
      total++; if ({err, cfg_ready, busy} !== 3'b110) begin bad++; $display("FAIL illegal%0d_err got=%b want=110", k, {err, cfg_ready, busy}); end
      tick();
      total++; if ({err, cfg_ready} !== 2'b01) begin bad++; $display("FAIL illegal%0d_after got=%b want=01", k, {err, cfg_ready}); end
    end
    $display("test_illegal complete");
  endtask

  task automatic test_gapped();
    logic [3:0] stream;
    logic [3:0] qv;
    int         early;
    stream = 4'b1101; qv = '0; early = 0;
    configure(8'b1101, 5'd4, 1'b1, 16'd4);
    do_start();
    for (int k = 3; k >= 0; k--) begin
      feed(stream[k]);
      qv = {qv[2:0], q};
      if (k != 0) begin
        if (done) early++;
        for (int g = 0; g < 3; g++) begin
          tick();
          if (done || q) early++;
        end
      end
    end
    total++; if (qv !== 4'b0001) begin bad++; $display("FAIL gap_q got=%b want=0001", qv); end
    total++; if (early !== 0) begin bad++; $display("FAIL gap_early got=%0d want=0", early); end
    total++; if ({done, match_cnt} !== {1'b1, 8'd1}) begin bad++; $display("FAIL gap_done got done=%0b cnt=%0d want done=1 cnt=1", done, match_cnt); end
    tick();
    go_idle();
    $display("test_gapped q=%b", qv);
  endtask

  task automatic test_saturation();
    logic [5:0] qv;
    qv = '0;
    configure(8'b1, 5'd1, 1'b1, 16'd6);
    do_start();
    for (int k = 0; k < 6; k++) begin feed(1'b1); qv = {qv[4:0], s_q}; end
    total++; if (qv !== 6'b111111) begin bad++; $display("FAIL sat_q got=%b want=111111", qv); end
    total++; if (s_match_cnt !== 2'd3) begin bad++; $display("FAIL sat_cnt got=%0d want=3", s_match_cnt); end
    total++; if (match_cnt !== 8'd6) begin bad++; $display("FAIL sat_widecnt got=%0d want=6", match_cnt); end
    tick();
    go_idle();
    $display("test_saturation cnt2=%0d cnt8=%0d", s_match_cnt, match_cnt);
  endtask

  task automatic test_back_to_back();
    logic [3:0] qv;
    qv = '0;
    configure(8'b11, 5'd2, 1'b1, 16'd4);
    do_start();
    for (int k = 0; k < 4; k++) begin feed(1'b1); qv = {qv[2:0], q}; end
    total++; if (qv !== 4'b0111) begin bad++; $display("FAIL b2b_q got=%b want=0111", qv); end
    start = 1'b1;
    tick();
    total++; if ({busy, done, match_cnt} !== {2'b00, 8'd3}) begin bad++; $display("FAIL b2b_done_start got busy=%0b done=%0b cnt=%0d want 0 0 3", busy, done, match_cnt); end
    tick();
    start = 1'b0;
    total++; if ({busy, match_cnt} !== {1'b1, 8'd0}) begin bad++; $display("FAIL b2b_restart got busy=%0b cnt=%0d want 1 0", busy, match_cnt); end
    go_idle();
    $display("test_back_to_back q=%b", qv);
  endtask

  task automatic test_abort();
    configure(8'b1, 5'd1, 1'b1, 16'd5);
    do_start();
    feed(1'b1); feed(1'b1);
    abort = 1'b1; i_valid = 1'b1; i = 1'b1;
    tick();
    abort = 1'b0; i_valid = 1'b0;
    total++; if ({cfg_ready, busy, done, q} !== 4'b1000) begin bad++; $display("FAIL abort_state got=%b want=1000", {cfg_ready, busy, done, q}); end
    total++; if (match_cnt !== 8'd2) begin bad++; $display("FAIL abort_cnt got=%0d want=2", match_cnt); end
    tick();
    total++; if ({done, match_cnt} !== {1'b0, 8'd2}) begin bad++; $display("FAIL abort_after got done=%0b cnt=%0d want 0 2", done, match_cnt); end
    // abort wins over a simultaneous start
    configure(8'b1, 5'd1, 1'b1, 16'd5);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    total++; if ({cfg_ready, busy} !== 2'b10) begin bad++; $display("FAIL abort_start got=%b want=10", {cfg_ready, busy}); end
    $display("test_abort cnt=%0d", match_cnt);
  endtask

  task automatic test_reset_midrun();
    configure(8'b1, 5'd1, 1'b1, 16'd5);
    do_start();
    feed(1'b1);
    total++; if ({q, busy} !== 2'b11) begin bad++; $display("FAIL rstmid_pre got=%b want=11", {q, busy}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({cfg_ready, q, busy, done, err} !== 5'b10000) begin bad++; $display("FAIL rstmid_outs got=%b want=10000", {cfg_ready, q, busy, done, err}); end
    total++; if (match_cnt !== 8'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d want=0", match_cnt); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%0b want=0", done); end
    $display("test_reset_midrun complete");
  endtask

  initial begin
    rst = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_frame = '0; start = 1'b0; abort = 1'b0; i_valid = 1'b0; i = 1'b0;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_illegal();
    test_gapped();
    test_saturation();
    test_back_to_back();
    test_abort();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
